full_system_schm: RTL and testbench

Top-level relative-prime engine that runs as a self-contained system. After reset it samples a 16-bit operand `n` from `Input` and searches for the smallest integer `m ≥ 2` with gcd(n, m) = 1. It publishes `m` on `finalOutput` and holds it there. A nonzero `finalOutput` is the system's only "done" indication, and `Cycles` reports how many clocks the run took.

---
 rtl/full_system_schm_if.sv | 24 ++
 rtl/full_system_schm.sv | 135 +++++++++++++
 tb/tb_full_system_schm.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/full_system_schm_if.sv
// Operand/result bundle of the relative-prime engine.
// The engine has no valid/ready handshake: Input is a level sampled once
// on the LOAD edge, and a nonzero finalOutput is the only completion flag.
interface full_system_schm_if #(
    parameter int CYC_W = 32
);
    logic [15:0]      Input;
    logic [15:0]      finalOutput;
    logic [CYC_W-1:0] Cycles;

    // Environment side: supplies the operand, observes the result.
    modport master (
        output Input,
        input  finalOutput,
        input  Cycles
    );

    // Engine side: consumes the operand, publishes the result.
    modport slave (
        input  Input,
        output finalOutput,
        output Cycles
    );
endinterface

// File: rtl/full_system_schm.sv
// Relative-prime engine: after reset and a short settling window it samples
// n from Input and searches m = 2, 3, ... for the first m with gcd(n, m) = 1,
// using subtractive Euclid (one subtract or swap per clock). The result is
// published on finalOutput and held; Cycles counts the clocks spent running.
// n = 0 has no answer and reports 16'hFFFF immediately.
module full_system_schm #(
    parameter int INIT_CYCLES = 4,   // must be >= 1
    parameter int CYC_W       = 32
) (
    input  logic                CLK,
    input  logic                Reset,
    full_system_schm_if.slave   bus,
    output logic [2:0]          dbg_state
);

    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_STEP  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic [15:0]      n_q, n_d;
    logic [15:0]      m_q, m_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic [15:0]      final_q, final_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;

    // Next-state and datapath: everything holds unless the current state acts.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        n_d        = n_q;
        m_d        = m_q;
        a_d        = a_q;
        b_d        = b_q;
        final_d    = final_q;
        cycles_d   = cycles_q;

        // Every running clock counts, including the one that enters DONE;
        // the counter sticks at all-ones rather than wrapping.
        if (state_q != S_DONE && cycles_q != {CYC_W{1'b1}}) begin
            cycles_d = cycles_q + 1'b1;
        end

        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_LOAD: begin
                n_d = bus.Input;
                if (bus.Input == 16'd0) begin
                    // gcd(0, m) = m, never 1: report the no-answer marker.
                    final_d = 16'hFFFF;
                    state_d = S_DONE;
                end else begin
                    m_d     = 16'd2;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                a_d     = n_q;
                b_d     = m_q;
                state_d = S_STEP;
            end
            S_STEP: begin
                // a >= b guards the subtraction, so it cannot underflow.
                if (b_q == 16'd0) begin
                    state_d = S_CHECK;
                end else if (a_q >= b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    a_d = b_q;
                    b_d = a_q;
                end
            end
            S_CHECK: begin
                // a now holds gcd(n, m). m stays small (<= 23 for 16-bit n).
                if (a_q == 16'd1) begin
                    final_d = m_q;
                    state_d = S_DONE;
                end else begin
                    m_d     = m_q + 16'd1;
                    state_d = S_SETUP;
                end
            end
            S_DONE: begin
                // Parked until Reset; outputs frozen.
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State register with synchronous reset that clears all residue of a run.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            n_q        <= '0;
            m_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            final_q    <= '0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            n_q        <= n_d;
            m_q        <= m_d;
            a_q        <= a_d;
            b_q        <= b_d;
            final_q    <= final_d;
            cycles_q   <= cycles_d;
        end
    end

    assign bus.finalOutput = final_q;
    assign bus.Cycles      = cycles_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_full_system_schm.sv
// Directed bench for full_system_schm: runs a sequence of operands with
// hand-computed answers and compares Cycles against a cycle-accurate model.
module tb_full_system_schm;

    localparam int INIT_CYCLES = 4;
    localparam int CYC_W       = 32;
    localparam int RUN_BUDGET  = 20000;

    logic       CLK;
    logic       Reset;
    logic [2:0] dbg_state;

    int vectors = 0;
    int errors  = 0;
    int unsigned last_cyc;

    full_system_schm_if #(.CYC_W(CYC_W)) bus ();

    full_system_schm #(
        .INIT_CYCLES (INIT_CYCLES),
        .CYC_W       (CYC_W)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Watchdog against a hung run
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle-accurate reference: INIT + LOAD, then per candidate SETUP,
    // Euclid steps (including the final b == 0 step) and CHECK.
    task automatic model(input logic [15:0] n, output int unsigned cyc, output logic [15:0] res);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        cyc = INIT_CYCLES + 1;
        res = 16'hFFFF;
        if (n != 16'd0) begin
            for (int unsigned c = 2; c < 100; c++) begin
                cyc++;
                a = n;
                b = c;
                while (1) begin
                    cyc++;
                    if (b == 0) break;
                    if (a >= b) a = a - b;
                    else begin
                        t = a;
                        a = b;
                        b = t;
                    end
                end
                cyc++;
                if (a == 1) begin
                    res = c[15:0];
                    break;
                end
            end
        end
    endtask

    // Assert Reset for len clocks, checking the cleared outputs each clock.
    task automatic apply_reset(input int len);
        @(negedge CLK);
        Reset = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            chk("rst_final", {16'd0, bus.finalOutput}, 32'd0);
            chk("rst_cycles", bus.Cycles, 32'd0);
        end
        Reset = 1'b0;
    endtask

    // Follow one run from reset release to DONE. If late > 0, Input is
    // switched to val that many clocks after release.
    task automatic run_case(input string tag, input logic [15:0] val, input int late,
                            input logic [15:0] exp_m);
        int unsigned exp_cyc;
        logic [15:0] mdl_m;
        int edges;
        logic done;
        model(val, exp_cyc, mdl_m);
        edges = 0;
        done  = 1'b0;
        while (!done && edges < RUN_BUDGET) begin
            @(negedge CLK);
            edges++;
            if (late > 0 && edges == late) bus.Input = val;
            if (bus.finalOutput != 16'd0) done = 1'b1;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_result"}, {16'd0, bus.finalOutput}, {16'd0, exp_m});
        chk({tag, "_model_result"}, {16'd0, bus.finalOutput}, {16'd0, mdl_m});
        chk({tag, "_cycles"}, bus.Cycles, exp_cyc);
        chk({tag, "_done_edge"}, edges, exp_cyc);
        repeat (3) @(negedge CLK);
        chk({tag, "_hold_result"}, {16'd0, bus.finalOutput}, {16'd0, exp_m});
        chk({tag, "_hold_cycles"}, bus.Cycles, exp_cyc);
        last_cyc = exp_cyc;
    endtask

    // Directed sequence
    initial begin
        Reset     = 1'b0;
        bus.Input = 16'd5040;

        // 5040 -> 11
        apply_reset(1);
        run_case("n5040", 16'd5040, 0, 16'd11);

        // Operand changed one clock after release; stale 5040 must not be used
        apply_reset(1);
        run_case("n2310", 16'd2310, 1, 16'd13);

        bus.Input = 16'd4095;
        apply_reset(1);
        run_case("n4095", 16'd4095, 0, 16'd2);

        bus.Input = 16'd1;
        apply_reset(1);
        run_case("n1", 16'd1, 0, 16'd2);
        chk("n1_cycles_hand", last_cyc, 32'd12);

        bus.Input = 16'd2;
        apply_reset(1);
        run_case("n2", 16'd2, 0, 16'd3);
        chk("n2_cycles_hand", last_cyc, 32'd19);

        bus.Input = 16'd30;
        apply_reset(1);
        run_case("n30", 16'd30, 0, 16'd7);

        bus.Input = 16'd210;
        apply_reset(1);
        run_case("n210", 16'd210, 0, 16'd11);

        // Zero operand: no-answer marker after INIT + LOAD
        bus.Input = 16'd0;
        apply_reset(1);
        run_case("n0", 16'd0, 0, 16'hFFFF);
        chk("n0_cycles_hand", last_cyc, INIT_CYCLES + 1);

        // Reset mid-search, held 3 clocks, then a new operand
        bus.Input = 16'd5040;
        apply_reset(1);
        repeat (20) @(negedge CLK);
        chk("mid_running_final", {16'd0, bus.finalOutput}, 32'd0);
        apply_reset(3);
        bus.Input = 16'd9;
        run_case("n9_after_mid", 16'd9, 0, 16'd2);

        // DONE holds for 100 clocks while Input toggles
        for (int i = 0; i < 100; i++) begin
            bus.Input = 16'($urandom_range(0, 65535));
            @(negedge CLK);
            chk("done_hold_final", {16'd0, bus.finalOutput}, 32'd2);
            chk("done_hold_cycles", bus.Cycles, last_cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
